// File: rtl/gpio_in_debounce.sv
// Pad input conditioning: two-flop synchronizer, then a per-pin debounce filter
// paced by a shared sample-tick prescaler. Emits clean data plus one-cycle change pulses.
module gpio_in_debounce #(
  parameter int NUM_PINS = 256,
  parameter int CNT_W    = 8,
  parameter int PRESC_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PINS-1:0] gpio_pad_in,
  input  logic [NUM_PINS-1:0] debounce_en,
  input  logic [CNT_W-1:0]    debounce_limit,
  input  logic [PRESC_W-1:0]  prescale,
  output logic [NUM_PINS-1:0] gpio_in_data,
  output logic [NUM_PINS-1:0] gpio_in_change,
  output logic                sample_tick
);

  logic [NUM_PINS-1:0] r_s1;
  logic [NUM_PINS-1:0] r_s2;
  logic [PRESC_W-1:0]  r_pc;
  logic                r_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= gpio_pad_in;
      r_s2 <= r_s1;
    end
  end

  // >= rather than == so a prescale decrease below the running count wraps at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_tick <= 1'b0;
    end else if (r_pc >= prescale) begin
      r_pc   <= '0;
      r_tick <= 1'b1;
    end else begin
      r_pc   <= r_pc + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign sample_tick = r_tick;

  for (genvar gi = 0; gi < NUM_PINS; gi++) begin : g_pin
    logic             r_st;
    logic             r_chg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_st_next;
    logic [CNT_W-1:0] w_cnt_next;

    // Any cycle where s2 matches the stable value cancels a pending change, tick or not.
    always_comb begin
      w_st_next  = r_st;
      w_cnt_next = r_cnt;
      if (!debounce_en[gi]) begin
        w_st_next  = r_s2[gi];
        w_cnt_next = '0;
      end else if (r_s2[gi] == r_st) begin
        w_cnt_next = '0;
      end else if (r_tick) begin
        if (r_cnt >= debounce_limit) begin
          w_st_next  = r_s2[gi];
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_st  <= 1'b0;
        r_chg <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_st  <= w_st_next;
        r_chg <= (w_st_next != r_st);
        r_cnt <= w_cnt_next;
      end
    end

    assign gpio_in_data[gi]   = r_st;
    assign gpio_in_change[gi] = r_chg;
  end

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Bench for gpio_in_debounce: directed timing cases plus randomized pad activity,
// all checked every cycle against a behavioural model of pad history and tick counts.
module tb_gpio_in_debounce;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] pad, en;
  logic [7:0]    lim;
  logic [15:0]   pre;
  logic [NP-1:0] data, chg;
  logic          tick;

  int checks = 0;
  int failures = 0;

  // Model state as seen after the most recent edge.
  logic [NP-1:0] m_st, m_chg, h1, h2;
  logic          m_tick;
  int            m_mis [NP];
  int            m_edges;

  always #5 clk = ~clk;

  gpio_in_debounce #(.NUM_PINS(NP), .CNT_W(8), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .gpio_pad_in(pad), .debounce_en(en),
    .debounce_limit(lim), .prescale(pre),
    .gpio_in_data(data), .gpio_in_change(chg), .sample_tick(tick)
  );

  task automatic chk(input string name, input logic [NP-1:0] act, input logic [NP-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // h2 is the pad value two edges old, i.e. what the filter sees at the next edge;
  // a tick is visible after every (pre+1)-th edge counted from reset release.
  task automatic step();
    logic [NP-1:0] nst;
    nst = m_st;
    if (rst) begin
      m_st = '0; m_chg = '0; h1 = '0; h2 = '0; m_tick = 1'b0; m_edges = 0;
      for (int i = 0; i < NP; i++) m_mis[i] = 0;
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (!en[i]) begin
          nst[i] = h2[i];
          m_mis[i] = 0;
        end else if (h2[i] == m_st[i]) begin
          m_mis[i] = 0;
        end else if (m_tick) begin
          if (m_mis[i] >= int'(lim)) begin
            nst[i] = h2[i];
            m_mis[i] = 0;
          end else begin
            m_mis[i]++;
          end
        end
      end
      m_chg = nst ^ m_st;
      m_st = nst;
      h2 = h1;
      h1 = pad;
      m_edges++;
      m_tick = ((m_edges % (int'(pre) + 1)) == 0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("data", data, m_st);
    chk("change", chg, m_chg);
    chk("tick", {{(NP-1){1'b0}}, tick}, {{(NP-1){1'b0}}, m_tick});
  endtask

  task automatic do_reset(input int p, input int l, input logic [NP-1:0] e);
    rst = 1'b1;
    pad = '0;
    pre = 16'(p);
    lim = 8'(l);
    en = e;
    step();
    step();
    rst = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    int acc;
    logic bad;
    rst = 1'b1; pad = '1; en = '0; lim = 8'd0; pre = 16'd0;

    // Reset with all pads high, then release: all-ones appear on the 3rd edge.
    repeat (3) begin
      step();
      chk("rst_data", data, '0);
      chk("rst_chg", chg, '0);
    end
    rst = 1'b0;
    step();
    step();
    chk("rel_data_early", data, '0);
    step();
    chk("rel_data", data, '1);
    chk("rel_chg", chg, '1);
    step();
    chk("rel_chg_clear", chg, '0);

    // Bypass latency on pin 5.
    do_reset(0, 0, '0);
    pad[5] = 1'b1;
    step();
    step();
    chk("byp_early", data, '0);
    step();
    chk("byp_data", data, 16'h0020);
    chk("byp_chg", chg, 16'h0020);
    step();
    chk("byp_chg_once", chg, '0);

    // Filter accept: prescale 3, limit 2, pin 0.
    do_reset(3, 2, 16'h0001);
    pad[0] = 1'b1;
    acc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (data[0]) begin
        acc = k;
        break;
      end
    end
    checks++;
    if (acc < 11 || acc > 14) begin
      failures++;
      $display("FAIL filt_latency: got %0d cycles expected 11..14", acc);
    end
    chk("filt_chg", chg, 16'h0001);
    step();
    chk("filt_chg_once", chg, '0);

    // Glitch reject: 6 cycles high never reaches 3 ticks.
    do_reset(3, 2, 16'h0001);
    pad[0] = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      step();
      bad = bad | data[0] | chg[0];
    end
    pad[0] = 1'b0;
    repeat (30) begin
      step();
      bad = bad | data[0] | chg[0];
    end
    chk("glitch", {{(NP-1){1'b0}}, bad}, '0);

    // prescale 0 / limit 0 filtered pin behaves like bypass.
    do_reset(0, 0, 16'h0002);
    pad[1] = 1'b1;
    step();
    step();
    chk("p0l0_early", data, '0);
    step();
    chk("p0l0_data", data, 16'h0002);

    // Limit drops from 5 to 1 with count at 3: accept on the next tick.
    do_reset(0, 5, 16'h0004);
    pad[2] = 1'b1;
    repeat (5) step();
    chk("limdrop_hold", data, '0);
    lim = 8'd1;
    step();
    chk("limdrop_data", data, 16'h0004);

    // Reset mid-count discards progress: full 5-tick count after release.
    do_reset(0, 4, 16'h0008);
    pad[3] = 1'b1;
    repeat (4) step();
    chk("rstmid_pre", data, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("rstmid_hold", data, '0);
    step();
    chk("rstmid_data", data, 16'h0008);

    // Enable cleared mid-count: data follows s2 on the next edge.
    do_reset(3, 5, 16'h0010);
    pad[4] = 1'b1;
    repeat (10) step();
    chk("endis_hold", data, '0);
    en[4] = 1'b0;
    step();
    chk("endis_data", data, 16'h0010);

    // Randomized segments, prescale fixed per segment, limit/enable drifting.
    for (int seg = 0; seg < 6; seg++) begin
      do_reset(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), NP'($urandom));
      repeat (400) begin
        if ($urandom_range(0, 7) == 0) pad = pad ^ NP'($urandom);
        if ($urandom_range(0, 3) == 0) pad[$urandom_range(0, NP-1)] ^= 1'b1;
        if ($urandom_range(0, 49) == 0) lim = 8'($urandom_range(0, 3));
        if ($urandom_range(0, 59) == 0) en[$urandom_range(0, NP-1)] ^= 1'b1;
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpio_in_debounce.md
# gpio_in_debounce

Input conditioning stage directly upstream of the GPIO controller's `gpio_in_data` port. Each raw pad input passes through a two-flop synchronizer and then an optional per-pin debounce filter. The filter is clocked by a shared sample-tick prescaler. The block delivers a clean, glitch-free input vector plus a one-cycle change pulse per pin to the controller's input and edge-interrupt logic.

## Interface
- `NUM_PINS`, 256, number of GPIO pins (matches controller width)
- `CNT_W`, 8, width of per-pin debounce counter and limit
- `PRESC_W`, 16, width of sample-tick prescaler
- `clk` input 1: single clock, all logic rising-edge
- `rst` input 1: reset, synchronous, active-high
- `gpio_pad_in` input NUM_PINS: raw asynchronous pad inputs
- `debounce_en` input NUM_PINS: per-pin filter enable; 0 = bypass
- `debounce_limit` input CNT_W: required consecutive mismatching sample ticks minus one
- `prescale` input PRESC_W: sample tick period minus one, in clk cycles
- `gpio_in_data` output NUM_PINS: conditioned inputs; feeds controller `gpio_in_data`
- `gpio_in_change` output NUM_PINS: one-cycle pulse on any bit whose `gpio_in_data` changed this cycle
- `sample_tick` output 1: registered prescaler strobe, for observability

## Operation
- **Synchronizer.** `s1 <= gpio_pad_in; s2 <= s1`, per bit. No filtering before `s2`.
- **Prescaler.**
  - Counter `pc` increments each clk.
  - When `pc >= prescale`: `pc <= 0` and `sample_tick` is 1 for that cycle.
  - `prescale = 0` gives a tick every cycle.
  - A `prescale` decrease below the current `pc` wraps on the next cycle; no lockup.
- **Per-pin state.** Stable value `st[i]` (drives `gpio_in_data[i]`) and counter `cnt[i]`.
- **Bypass (`debounce_en[i] = 0`).**
  - `st[i] <= s2[i]` every cycle.
  - `cnt[i] <= 0`.
- **Filter (`debounce_en[i] = 1`).**
  - If `s2[i] == st[i]`: `cnt[i] <= 0`. This holds every cycle, not only on ticks, so any return to the stable value cancels a pending change.
  - Else if `sample_tick` and `cnt[i] == debounce_limit`: `st[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else if `sample_tick`: `cnt[i] <= cnt[i] + 1`.
  - Else: hold.
  - A change is therefore accepted on the (`debounce_limit`+1)-th tick observing a continuous mismatch. `debounce_limit = 0` accepts on the first mismatching tick.
  - `cnt` never exceeds `debounce_limit`, so no wrap.
- **Limit change mid-count.** If `debounce_limit` drops below the current `cnt[i]`, use compare `cnt[i] >= debounce_limit`. The pin accepts on the next tick.
- **Enable toggle.** 1→0 mid-count clears `cnt[i]`; `st` follows `s2` from the next edge. 0→1 starts filtering from the current `st`.
- **Change pulse.** `gpio_in_change[i] <= (next_st[i] != st[i])`, registered in the same edge as `st`, so the pulse and the new data appear in the same cycle.
- **Reset.** `s1`, `s2`, `st`, `cnt`, `pc`, `gpio_in_change`, `sample_tick` all go to 0.
  - After reset, pins held high propagate as a normal 0→1 change, with a pulse.
  - Reset mid-count discards pending changes.

## Timing
- Reset values: `gpio_in_data = 0`, `gpio_in_change = 0`, `sample_tick = 0`.
- Bypass latency: pad change captured at edge E appears on `gpio_in_data` after edge E+2 (`s1` at E, `s2` at E+1, `st` at E+2).
- Filter latency: `st` updates at the edge where the (`debounce_limit`+1)-th tick sees `s2 != st`.
  - Worst case: 2 + (`debounce_limit`+1)·(`prescale`+1) cycles.
  - Best case: 2 + `debounce_limit`·(`prescale`+1) + 1 cycles.
- `gpio_in_change`: high exactly one cycle per accepted transition, aligned with the `gpio_in_data` update.
- The controller samples `gpio_in_data` as a synchronous signal; it needs no further synchronization.
- All pins share one `sample_tick`; simultaneous changes on many pins are accepted on the same edge.

## Test plan
- **Reset.** Assert `rst` with `gpio_pad_in = all 1`, then release → outputs 0 during reset. With `debounce_en = 0`, `gpio_in_data` = all 1 on the 3rd cycle after release, and `gpio_in_change` = all 1 for one cycle.
- **Bypass latency.** `debounce_en = 0`; toggle `gpio_pad_in[5]` 0→1 → `gpio_in_data[5]` rises 3 edges later, with a single change pulse.
- **Filter accept.** `debounce_en[0] = 1`, `prescale = 3`, `debounce_limit = 2`; hold pin 0 high → update on the 3rd consecutive mismatching tick, between 11 and 14 cycles after the pad edge, with a one-cycle pulse.
- **Glitch reject.** Same configuration; pulse pin 0 high for 6 cycles, then low → `gpio_in_data[0]` stays 0, no pulse, `cnt` returns to 0.
- **Boundaries.**
  - `prescale = 0`, `debounce_limit = 0` → filtered pin behaves like bypass.
  - Drop `debounce_limit` from 5 to 1 while `cnt = 3` → accept on the next tick.
- **Reset / enable mid-operation.**
  - Assert `rst` while `cnt = 2` → no update after release until a full new count.
  - Clear `debounce_en` mid-count → `st` follows `s2` the next cycle.
